// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer: debounced start/load keys, 1 Hz countdown,
// active-low seven-segment digits and status LEDs.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 500,
  parameter int unsigned DEBOUNCE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_load_n,
  input  logic [7:0] load_val,
  output logic [7:0] count_bcd,
  output logic [7:0] hex_units,
  output logic [7:0] hex_tens,
  output logic       tick,
  output logic       running,
  output logic       done,
  output logic       alarm_led
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICK_DIV / 2);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic [PRE_W-1:0] pre_inc;
  logic             wrap;
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       press;
  logic [DB_W-1:0]  db_cnt [2];
  logic             start_ev;
  logic             load_ev;
  logic [7:0]       count_dec;
  logic [7:0]       load_clamped;

  // Key index 0 is start, 1 is load.
  assign raw      = {key_load_n, key_start_n};
  assign start_ev = press[0];
  assign load_ev  = press[1];

  // Synchronize, debounce and turn debounced presses into one-cycle events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      deb       <= 2'b11;
      press     <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == deb[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          deb[k]    <= sync2[k];
          db_cnt[k] <= '0;
          press[k]  <= ~sync2[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  assign wrap    = (prescaler == PRE_LAST);
  assign pre_inc = wrap ? '0 : prescaler + PRE_W'(1);

  // BCD decrement with borrow; never applied at 00.
  assign count_dec = (count_bcd[3:0] == 4'd0) ? {count_bcd[7:4] - 4'd1, 4'd9}
                                              : {count_bcd[7:4], count_bcd[3:0] - 4'd1};

  assign load_clamped = {(load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4],
                         (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0]};

  // Timer FSM; status outputs are registered alongside the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count_bcd <= 8'h00;
      prescaler <= '0;
      tick      <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      alarm_led <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load_ev) begin
        state     <= IDLE;
        count_bcd <= load_clamped;
        prescaler <= '0;
        running   <= 1'b0;
        done      <= 1'b0;
        alarm_led <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ev && (count_bcd != 8'h00)) begin
              state     <= RUN;
              prescaler <= '0;
              running   <= 1'b1;
            end
          end
          RUN: begin
            prescaler <= pre_inc;
            if (wrap) begin
              tick      <= 1'b1;
              count_bcd <= count_dec;
            end
            // Reaching 00 beats a same-cycle pause request.
            if (wrap && (count_dec == 8'h00)) begin
              state     <= DONE;
              running   <= 1'b0;
              done      <= 1'b1;
              alarm_led <= 1'b1;
            end else if (start_ev) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: begin
            if (start_ev) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            prescaler <= pre_inc;
            if (start_ev) begin
              state     <= IDLE;
              done      <= 1'b0;
              alarm_led <= 1'b0;
            end else begin
              alarm_led <= (pre_inc < PRE_HALF);
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign hex_units = seg7(count_bcd[3:0]);
  assign hex_tens  = seg7(count_bcd[7:4]);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with a 10-cycle tick and
// 10-sample debounce so every expected timing is hand-countable.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_load_n = 1'b1;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count_bcd;
  logic [7:0] hex_units;
  logic [7:0] hex_tens;
  logic       tick;
  logic       running;
  logic       done;
  logic       alarm_led;

  int tests = 0;
  int fails = 0;
  int ticks_seen;

  countdown_timer #(.TICK_DIV(10), .DEBOUNCE(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start_n(key_start_n),
    .key_load_n (key_load_n),
    .load_val   (load_val),
    .count_bcd  (count_bcd),
    .hex_units  (hex_units),
    .hex_tens   (hex_tens),
    .tick       (tick),
    .running    (running),
    .done       (done),
    .alarm_led  (alarm_led)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // A key held low is seen by the FSM on the 13th edge (2 sync + 10 debounce + 1).
  task automatic load_value(input logic [7:0] v);
    load_val   = v;
    key_load_n = 1'b0;
    step(13);
    key_load_n = 1'b1;
  endtask

  initial begin
    step(3);
    chk("rst_count", count_bcd, 8'h00);
    chk("rst_hex_u", hex_units, 8'hC0);
    chk("rst_hex_t", hex_tens, 8'hC0);
    chk("rst_flags", {4'b0, tick, running, done, alarm_led}, 8'h00);
    rst = 1'b0;
    step(2);

    // Load 25 with the key held for 20 cycles.
    load_val   = 8'h25;
    key_load_n = 1'b0;
    step(20);
    chk("load25_count", count_bcd, 8'h25);
    chk("load25_hex_t", hex_tens, 8'hA4);
    chk("load25_hex_u", hex_units, 8'h92);
    chk("load25_running", running, 1'b0);
    key_load_n = 1'b1;
    step(14);

    // Bouncing start key: only the final stable low produces an event.
    for (int i = 0; i < 10; i++) begin
      key_start_n = (i % 2 == 1);
      step(3);
    end
    chk("bounce_no_event", running, 1'b0);
    key_start_n = 1'b0;
    step(12);
    chk("bounce_before", running, 1'b0);
    step(1);
    chk("bounce_latency", running, 1'b1);
    step(30);
    chk("bounce_single", running, 1'b1);
    key_start_n = 1'b1;
    step(14);

    // Count 03 down to DONE.
    load_value(8'h03);
    chk("load03_count", count_bcd, 8'h03);
    chk("load03_idle", running, 1'b0);
    step(14);
    key_start_n = 1'b0;
    step(13);
    chk("run_running", running, 1'b1);
    chk("run_count", count_bcd, 8'h03);
    key_start_n = 1'b1;
    step(9);
    chk("run_pre_tick", {tick, count_bcd}, 9'h003);
    step(1);
    chk("run_tick1", {tick, count_bcd}, 9'h102);
    step(1);
    chk("run_tick_pulse", tick, 1'b0);
    step(9);
    chk("run_tick2", {tick, count_bcd}, 9'h101);
    step(10);
    chk("done_count", count_bcd, 8'h00);
    chk("done_flags", {tick, running, done}, 3'b101);
    for (int i = 0; i < 10; i++) begin
      chk("alarm_blink", alarm_led, (i < 5) ? 1'b1 : 1'b0);
      step(1);
    end
    key_start_n = 1'b0;
    step(13);
    chk("done_exit", {running, done, alarm_led}, 3'b000);
    chk("done_exit_count", count_bcd, 8'h00);
    key_start_n = 1'b1;
    step(14);

    // Start at 00 in IDLE is ignored.
    key_start_n = 1'b0;
    step(13);
    chk("idle00_start", {running, done}, 2'b00);
    key_start_n = 1'b1;
    step(14);

    // Clamp and borrow.
    load_value(8'hA0);
    chk("clamp_A0", count_bcd, 8'h90);
    step(14);
    key_start_n = 1'b0;
    step(13);
    key_start_n = 1'b1;
    step(10);
    chk("borrow_89", {tick, count_bcd}, 9'h189);
    load_value(8'h10);
    chk("load10_count", count_bcd, 8'h10);
    chk("load_in_run_idle", running, 1'b0);
    step(14);
    key_start_n = 1'b0;
    step(13);
    key_start_n = 1'b1;
    step(10);
    chk("borrow_09", {tick, count_bcd}, 9'h109);

    // Pause and resume with the prescaler frozen at 7.
    load_value(8'h50);
    step(14);
    key_start_n = 1'b0;
    step(13);
    key_start_n = 1'b1;
    step(14);
    key_start_n = 1'b0;
    step(13);
    chk("pause_running", running, 1'b0);
    chk("pause_count", count_bcd, 8'h48);
    key_start_n = 1'b1;
    ticks_seen = 0;
    repeat (100) begin
      step(1);
      if (tick) ticks_seen++;
    end
    chk("pause_no_tick", 8'(ticks_seen), 8'd0);
    chk("pause_hold", count_bcd, 8'h48);
    key_start_n = 1'b0;
    step(13);
    chk("resume_running", {running, tick}, 2'b10);
    step(2);
    chk("resume_pre9", tick, 1'b0);
    step(1);
    chk("resume_tick", {tick, count_bcd}, 9'h147);
    key_start_n = 1'b1;
    step(14);

    // Load and start on the same cycle: load wins, start dropped.
    load_val    = 8'h35;
    key_load_n  = 1'b0;
    key_start_n = 1'b0;
    step(13);
    chk("prio_count", count_bcd, 8'h35);
    chk("prio_idle", running, 1'b0);
    step(20);
    chk("prio_dropped", {running, count_bcd}, 9'h035);
    key_load_n  = 1'b1;
    key_start_n = 1'b1;
    step(14);

    // Start event on the tick that reaches 00: DONE wins over PAUSE.
    load_value(8'h03);
    step(14);
    key_start_n = 1'b0;
    step(13);
    key_start_n = 1'b1;
    step(17);
    key_start_n = 1'b0;
    step(13);
    chk("tick_start_done", {tick, running, done}, 3'b101);
    chk("tick_start_count", count_bcd, 8'h00);
    key_start_n = 1'b1;
    step(14);

    // Asynchronous reset in the middle of RUN.
    load_value(8'h20);
    step(14);
    key_start_n = 1'b0;
    step(13);
    key_start_n = 1'b1;
    step(15);
    chk("pre_rst_running", running, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_count", count_bcd, 8'h00);
    chk("arst_hex", {hex_tens, hex_units} == 16'hC0C0, 1'b1);
    chk("arst_flags", {tick, running, done, alarm_led}, 4'b0000);
    step(2);
    rst = 1'b0;
    step(20);
    chk("post_rst_idle", {running, count_bcd}, 9'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
